m_dm_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline M stage (CPU port) and a debug/loader port (DBG port).
//  CPU accesses are single-beat and read data is combinational in the same cycle; DBG accesses are bursts of 1..MAX_BURST words.

---
 rtl/m_dm_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_m_dm_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dm_arbiter.sv
// Data-memory arbiter: shares the single-port DM between the CPU M stage
// (single-beat, zero wait states) and a debug/loader port (bursts of 1..MAX_BURST
// words). Round-robin on conflict; a DBG burst owns the memory until its last beat.
module m_dm_arbiter #(
    parameter int unsigned DEPTH     = 3072,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LEN_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_gnt,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_addr,
    input  logic [LEN_W-1:0] dbg_len,
    input  logic [31:0]      dbg_wdata,
    output logic             dbg_gnt,
    output logic [LEN_W-1:0] dbg_beat_idx,
    output logic             dbg_last,
    output logic             dbg_rvalid,
    output logic [31:0]      dbg_rdata,
    output logic [31:0]      dm_A,
    output logic [31:0]      dm_WD,
    output logic             dm_DMWr,
    input  logic [31:0]      dm_RD,
    output logic             err
);

    typedef enum logic {
        S_ARB   = 1'b0,
        S_BURST = 1'b1
    } state_e;

    localparam logic [30:0]      DEPTH_W = 31'(DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [29:0]      base_q, base_d;
    logic             we_q, we_d;
    logic             last_dbg_q, last_dbg_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [LEN_W-1:0] len_eff;
    logic             acc;
    logic             acc_we;
    logic [30:0]      acc_word;
    logic [31:0]      acc_wd;
    logic             in_range;

    // Byte-offset bits of both address ports are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[1:0], dbg_addr[1:0]};

    // Effective burst length: 0 means one beat, oversize requests are clamped.
    always_comb begin
        len_eff = dbg_len;
        if (dbg_len == '0) begin
            len_eff = ONE_LEN;
        end else if (dbg_len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
    end

    // State register and burst context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_ARB;
            beat_cnt_q <= '0;
            len_q      <= ONE_LEN;
            base_q     <= '0;
            we_q       <= 1'b0;
            last_dbg_q <= 1'b1;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            we_q       <= we_d;
            last_dbg_q <= last_dbg_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // Grant decision, next state and DM address/write path; all grants gated by reset.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        base_d       = base_q;
        we_d         = we_q;
        last_dbg_d   = last_dbg_q;
        err_d        = err_q;
        rvalid_d     = 1'b0;
        cpu_gnt      = 1'b0;
        dbg_gnt      = 1'b0;
        dbg_beat_idx = '0;
        dbg_last     = 1'b0;
        acc          = 1'b0;
        acc_we       = 1'b0;
        acc_word     = '0;
        acc_wd       = '0;
        in_range     = 1'b0;
        dm_A         = '0;
        dm_WD        = '0;
        dm_DMWr      = 1'b0;

        if (!reset) begin
            case (state_q)
                S_ARB: begin
                    if (cpu_req && (!dbg_req || last_dbg_q)) begin
                        cpu_gnt    = 1'b1;
                        acc        = 1'b1;
                        acc_we     = cpu_we;
                        acc_word   = {1'b0, cpu_addr[31:2]};
                        acc_wd     = cpu_wdata;
                        last_dbg_d = 1'b0;
                    end else if (dbg_req) begin
                        dbg_gnt  = 1'b1;
                        acc      = 1'b1;
                        acc_we   = dbg_we;
                        acc_word = {1'b0, dbg_addr[31:2]};
                        acc_wd   = dbg_wdata;
                        len_d    = len_eff;
                        base_d   = dbg_addr[31:2];
                        we_d     = dbg_we;
                        if (len_eff == ONE_LEN) begin
                            dbg_last   = 1'b1;
                            last_dbg_d = 1'b1;
                        end else begin
                            state_d    = S_BURST;
                            beat_cnt_d = ONE_LEN;
                        end
                    end
                end
                S_BURST: begin
                    dbg_gnt      = 1'b1;
                    dbg_beat_idx = beat_cnt_q;
                    acc          = 1'b1;
                    acc_we       = we_q;
                    acc_word     = {1'b0, base_q} + 31'(beat_cnt_q);
                    acc_wd       = dbg_wdata;
                    if (beat_cnt_q == LEN_W'(len_q - ONE_LEN)) begin
                        dbg_last   = 1'b1;
                        state_d    = S_ARB;
                        beat_cnt_d = '0;
                        last_dbg_d = 1'b1;
                    end else begin
                        beat_cnt_d = LEN_W'(beat_cnt_q + ONE_LEN);
                    end
                end
                default: state_d = S_ARB;
            endcase
        end

        if (acc) begin
            in_range = (acc_word < DEPTH_W);
            dm_A     = {acc_word[29:0], 2'b00};
            dm_WD    = acc_wd;
            dm_DMWr  = acc_we & in_range;
            err_d    = err_q | ~in_range;
            rvalid_d = dbg_gnt & ~acc_we;
        end
    end

    // Read-data return path, kept apart from the address path so dm_RD never feeds it.
    always_comb begin
        cpu_rdata = '0;
        rdata_d   = rdata_q;
        if (cpu_gnt && in_range) begin
            cpu_rdata = dm_RD;
        end
        if (dbg_gnt && !acc_we) begin
            rdata_d = in_range ? dm_RD : 32'h0;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_m_dm_arbiter.sv
// Bench for m_dm_arbiter: vector table for single-cycle arbitration plus burst,
// range-check and reset-abort sequences; DBG read data tracked through a queue.
module tb_m_dm_arbiter;

    localparam int unsigned DEPTH = 3072;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [4:0]  dbg_len;
    logic        dbg_gnt, dbg_last, dbg_rvalid;
    logic [4:0]  dbg_beat_idx;
    logic [31:0] dbg_rdata;
    logic [31:0] dm_A, dm_WD, dm_RD;
    logic        dm_DMWr;
    logic        err;

    logic [31:0] mem [0:4095];
    logic [31:0] sb_q [$];
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wd;
        logic        d_req, d_we;
        logic [31:0] d_addr;
        logic [4:0]  d_len;
        logic [31:0] d_wd;
        logic        e_cgnt, e_stall, e_dgnt, e_last, e_wr, e_rvalid;
        logic [31:0] e_crd, e_dmA;
        logic        push;
        logic [31:0] push_val;
    } vec_t;

    vec_t tbl [$];

    m_dm_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_beat_idx(dbg_beat_idx),
        .dbg_last(dbg_last), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dm_A(dm_A), .dm_WD(dm_WD), .dm_DMWr(dm_DMWr), .dm_RD(dm_RD), .err(err)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write at posedge.
    assign dm_RD = (dm_A[31:14] == 18'h0) ? mem[dm_A[13:2]] : 32'h0;
    always @(posedge clk) begin
        if (dm_DMWr && dm_A[31:14] == 18'h0) mem[dm_A[13:2]] <= dm_WD;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every registered DBG read result must match the oldest pending expectation.
    always @(negedge clk) begin
        if (dbg_rvalid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL dbg_rvalid: unexpected pulse, data %h expected none", dbg_rdata);
            end else begin
                chk("dbg_rdata", dbg_rdata, sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_len = 0; dbg_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " cpu_gnt"},    32'(cpu_gnt), 32'h0);
        chk({tag, " dbg_gnt"},    32'(dbg_gnt), 32'h0);
        chk({tag, " dbg_last"},   32'(dbg_last), 32'h0);
        chk({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
        chk({tag, " dbg_rdata"},  dbg_rdata, 32'h0);
        chk({tag, " cpu_rdata"},  cpu_rdata, 32'h0);
        chk({tag, " dm_A"},       dm_A, 32'h0);
        chk({tag, " dm_WD"},      dm_WD, 32'h0);
        chk({tag, " dm_DMWr"},    32'(dm_DMWr), 32'h0);
        chk({tag, " err"},        32'(err), 32'h0);
    endtask

    // Runs n_run beats of a DBG burst of n_total beats; DBG must win beat 0.
    task automatic burst(input logic we, input logic [31:0] addr, input logic [4:0] len,
                         input int n_run, input int n_total, input logic [31:0] pat,
                         input logic hold_cpu);
        logic inr;
        for (int i = 0; i < n_run; i++) begin
            dbg_req = (i == 0); dbg_we = we; dbg_addr = addr; dbg_len = len;
            dbg_wdata = pat + 32'(i);
            cpu_req = hold_cpu; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
            inr = ((addr >> 2) + 32'(i)) < DEPTH;
            if (!we) sb_q.push_back(inr ? pat + 32'(i) : 32'h0);
            @(negedge clk);
            chk($sformatf("burst %h b%0d dbg_gnt", addr, i), 32'(dbg_gnt), 32'h1);
            chk($sformatf("burst %h b%0d beat_idx", addr, i), 32'(dbg_beat_idx), 32'(i));
            chk($sformatf("burst %h b%0d dbg_last", addr, i), 32'(dbg_last), 32'(i == n_total - 1));
            chk($sformatf("burst %h b%0d dm_A", addr, i), dm_A, (addr & ~32'h3) + 32'(4 * i));
            chk($sformatf("burst %h b%0d dm_DMWr", addr, i), 32'(dm_DMWr), 32'(we && inr));
            chk($sformatf("burst %h b%0d cpu_gnt", addr, i), 32'(cpu_gnt), 32'h0);
            chk($sformatf("burst %h b%0d cpu_stall", addr, i), 32'(cpu_stall), 32'(hold_cpu));
            if (we) chk($sformatf("burst %h b%0d dm_WD", addr, i), dm_WD, pat + 32'(i));
            next_cycle();
        end
        dbg_req = 1'b0;
    endtask

    task automatic cpu_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic e_wr, input logic [31:0] e_rd);
        idle_inputs();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        chk({tag, " cpu_gnt"},   32'(cpu_gnt), 32'h1);
        chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'h0);
        chk({tag, " dm_DMWr"},   32'(dm_DMWr), 32'(e_wr));
        chk({tag, " dm_A"},      dm_A, addr & ~32'h3);
        if (!we) chk({tag, " cpu_rdata"}, cpu_rdata, e_rd);
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[3072] = 32'hBAD0_0BAD;
        mem[3073] = 32'hBAD0_0BAD;

        // {cpu: req we addr wdata} {dbg: req we addr len wdata} {exp: cgnt stall dgnt last wr rvalid crd dmA} {push val}
        tbl.push_back('{Y,Y,32'h10,32'h1234_5678, Y,N,32'h10,5'd1,32'h0, Y,N,N,N,Y,N, 32'h0,32'h10, N,32'h0});
        tbl.push_back('{Y,N,32'h10,32'h0, Y,N,32'h10,5'd1,32'h0, N,Y,Y,Y,N,N, 32'h0,32'h10, Y,32'h1234_5678});
        tbl.push_back('{Y,N,32'h10,32'h0, Y,N,32'h14,5'd1,32'h0, Y,N,N,N,N,Y, 32'h1234_5678,32'h10, N,32'h0});
        tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,5'd0,32'h0, N,N,N,N,N,N, 32'h0,32'h0, N,32'h0});
        tbl.push_back('{Y,N,32'h13,32'h0, N,N,32'h0,5'd0,32'h0, Y,N,N,N,N,N, 32'h1234_5678,32'h10, N,32'h0});
        tbl.push_back('{N,N,32'h0,32'h0, Y,N,32'h12,5'd0,32'h0, N,N,Y,Y,N,N, 32'h0,32'h10, Y,32'h1234_5678});
        tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,5'd0,32'h0, N,N,N,N,N,Y, 32'h0,32'h0, N,32'h0});
        tbl.push_back('{N,N,32'h0,32'h0, Y,Y,32'h20,5'd1,32'hCAFE_0001, N,N,Y,Y,Y,N, 32'h0,32'h20, N,32'h0});
        tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,5'd0,32'h0, N,N,N,N,N,N, 32'h0,32'h0, N,32'h0});
        tbl.push_back('{Y,N,32'h20,32'h0, N,N,32'h0,5'd0,32'h0, Y,N,N,N,N,N, 32'hCAFE_0001,32'h20, N,32'h0});
        tbl.push_back('{Y,Y,32'h28,32'h77, Y,Y,32'h24,5'd0,32'h5A5A_0000, N,Y,Y,Y,Y,N, 32'h0,32'h24, N,32'h0});
        tbl.push_back('{Y,N,32'h24,32'h0, N,N,32'h0,5'd0,32'h0, Y,N,N,N,N,N, 32'h5A5A_0000,32'h24, N,32'h0});

        do_reset();
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();

        // Single-cycle arbitration vectors.
        for (int k = 0; k < tbl.size(); k++) begin
            cpu_req = tbl[k].c_req; cpu_we = tbl[k].c_we; cpu_addr = tbl[k].c_addr; cpu_wdata = tbl[k].c_wd;
            dbg_req = tbl[k].d_req; dbg_we = tbl[k].d_we; dbg_addr = tbl[k].d_addr;
            dbg_len = tbl[k].d_len; dbg_wdata = tbl[k].d_wd;
            if (tbl[k].push) sb_q.push_back(tbl[k].push_val);
            @(negedge clk);
            chk($sformatf("v%0d cpu_gnt", k),    32'(cpu_gnt),      32'(tbl[k].e_cgnt));
            chk($sformatf("v%0d cpu_stall", k),  32'(cpu_stall),    32'(tbl[k].e_stall));
            chk($sformatf("v%0d dbg_gnt", k),    32'(dbg_gnt),      32'(tbl[k].e_dgnt));
            chk($sformatf("v%0d dbg_last", k),   32'(dbg_last),     32'(tbl[k].e_last));
            chk($sformatf("v%0d beat_idx", k),   32'(dbg_beat_idx), 32'h0);
            chk($sformatf("v%0d dm_DMWr", k),    32'(dm_DMWr),      32'(tbl[k].e_wr));
            chk($sformatf("v%0d dbg_rvalid", k), 32'(dbg_rvalid),   32'(tbl[k].e_rvalid));
            chk($sformatf("v%0d cpu_rdata", k),  cpu_rdata,         tbl[k].e_crd);
            chk($sformatf("v%0d dm_A", k),       dm_A,              tbl[k].e_dmA);
            next_cycle();
        end
        idle_inputs();

        // Full-length write burst, then an oversize read request clamped to 16 beats.
        burst(1'b1, 32'h200, 5'd16, 16, 16, 32'hA0, 1'b0);
        burst(1'b0, 32'h200, 5'd20, 16, 16, 32'hA0, 1'b0);
        idle_inputs();
        @(negedge clk);
        chk("clamp end dbg_gnt", 32'(dbg_gnt), 32'h0);
        next_cycle();

        // Write burst of 4 with the CPU held off; CPU then wins the next conflict.
        cpu_access("pre-burst cpu", 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678);
        burst(1'b1, 32'h100, 5'd4, 4, 4, 32'hA0, 1'b1);
        cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10; dbg_len = 5'd1;
        @(negedge clk);
        chk("post-burst cpu_gnt", 32'(cpu_gnt), 32'h1);
        chk("post-burst cpu_stall", 32'(cpu_stall), 32'h0);
        chk("post-burst dbg_gnt", 32'(dbg_gnt), 32'h0);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) chk($sformatf("mem[%0h]", 32'h40 + i), mem[32'h40 + i], 32'hA0 + 32'(i));
        chk("mem[44] untouched", mem[32'h44], 32'h0);

        // Out-of-range CPU access and a burst straddling the top of memory.
        @(negedge clk);
        chk("err before oor", 32'(err), 32'h0);
        next_cycle();
        cpu_access("oor store", 1'b1, 32'h3000, 32'hDEAD_0000, 1'b0, 32'h0);
        @(negedge clk);
        chk("err after oor store", 32'(err), 32'h1);
        next_cycle();
        cpu_access("oor load", 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0);
        burst(1'b1, 32'h2FF8, 5'd4, 4, 4, 32'hA0, 1'b0);
        idle_inputs();
        next_cycle();
        chk("mem[3070]", mem[3070], 32'hA0);
        chk("mem[3071]", mem[3071], 32'hA1);
        chk("mem[3072]", mem[3072], 32'hBAD0_0BAD);
        chk("mem[3073]", mem[3073], 32'hBAD0_0BAD);
        chk("err held", 32'(err), 32'h1);

        // Reset arriving on beat 2 of an 8-beat write aborts the burst.
        do_reset();
        burst(1'b1, 32'h400, 5'd8, 2, 8, 32'hB0, 1'b0);
        reset = 1'b1;
        dbg_wdata = 32'hB2;
        @(negedge clk);
        chk("reset beat dbg_gnt", 32'(dbg_gnt), 32'h0);
        chk("reset beat dm_DMWr", 32'(dm_DMWr), 32'h0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_all_zero("after abort");
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            dbg_wdata = 32'hB3 + 32'(i);
            @(negedge clk);
            chk($sformatf("idle %0d dbg_gnt", i), 32'(dbg_gnt), 32'h0);
            chk($sformatf("idle %0d dm_DMWr", i), 32'(dm_DMWr), 32'h0);
            next_cycle();
        end
        idle_inputs();
        chk("mem[100]", mem[32'h100], 32'hB0);
        chk("mem[101]", mem[32'h101], 32'hB1);
        for (int i = 3; i < 8; i++) chk($sformatf("mem[%0h] unwritten", 32'h100 + i), mem[32'h100 + i], 32'h0);
        cpu_access("post-abort cpu", 1'b0, 32'h400, 32'h0, 1'b0, 32'hB0);

        next_cycle();
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
